ha_serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder/accumulator built from two half-adder cells and
//   a carry flop. It sits directly downstream of the half-adder cell inside the

---
 rtl/ha_serial_adder.sv | 116 +++++++++++
 tb/tb_ha_serial_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ha_serial_adder.sv
// Bit-serial WIDTH-bit adder/accumulator built from two half-adder cells and a carry flop.
// It adds one operand bit per enabled clock and presents a registered sum, carry-out and done pulse.

module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module ha_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("ha_serial_adder: WIDTH must be in 2..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;

    logic             s1;
    logic             c1;
    logic             s2;
    logic             c2;
    logic             carry_next;
    logic [WIDTH-1:0] op_a_next;

    // Full-adder slice from two half adders; op_a doubles as the result shifter.
    ha_cell u_ha1 (.x(op_a[0]), .y(op_b[0]), .s(s1), .c(c1));
    ha_cell u_ha2 (.x(s1),      .y(carry),   .s(s2), .c(c2));

    assign carry_next = c1 | c2;
    assign op_a_next  = {s2, op_a[WIDTH-1:1]};

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a    <= acc ? sum : a;
                        op_b    <= b;
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    op_a    <= op_a_next;
                    op_b    <= op_b >> 1;
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    // Capture the final shifted word so sum is valid alongside done.
                    if (bit_cnt == LAST_BIT) begin
                        sum       <= op_a_next;
                        carry_out <= carry_next;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ha_serial_adder.sv
// Scoreboard bench for ha_serial_adder: stimulus queues expected results,
// a negedge monitor pops and compares them whenever done is presented.

module tb_ha_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       acc;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;

    ha_serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .acc       (acc),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every enabled done cycle must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && ena && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got sum=0x%0h carry_out=%0b with no result pending",
                         sum, carry_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", {24'h0, sum}, {24'h0, mon_e.sum});
                check("carry_out", {31'h0, carry_out}, {31'h0, mon_e.cout});
            end
        end
    end

    // One operation. Edge 1 is the edge that accepts start; *_at values are
    // edge numbers after which the event is applied (0 = never).
    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic use_acc, input logic [7:0] exp_sum, input logic exp_c,
                          input int exp_lat, input int pause_at, input int pause_len,
                          input int inject_at, input int reset_at);
        exp_t e;
        int   edges;
        int   busy_cycles;
        bit   seen;
        e.sum  = exp_sum;
        e.cout = exp_c;
        if (reset_at == 0) exp_q.push_back(e);
        a           = op_a;
        b           = op_b;
        acc         = use_acc;
        start       = 1'b1;
        edges       = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (!seen && edges < 40) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
            if (edges == inject_at) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'hAA;
            end else begin
                start = 1'b0;
            end
            if (pause_at != 0 && edges == pause_at) ena = 1'b0;
            if (pause_at != 0 && edges == pause_at + pause_len) ena = 1'b1;
            if (edges == reset_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, {31'h0, busy}, 32'h0);
                check({tag, "_rst_done"}, {31'h0, done}, 32'h0);
                check({tag, "_rst_sum"}, {24'h0, sum}, 32'h0);
                check({tag, "_rst_carry"}, {31'h0, carry_out}, 32'h0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (12) @(negedge clk);
                check({tag, "_no_done_after_abort"}, {31'h0, busy}, 32'h0);
                return;
            end
        end
        check({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_busy_cycles"}, busy_cycles, exp_lat);
        @(negedge clk);
        check({tag, "_done_pulse_width"}, {31'h0, done}, 32'h0);
        check({tag, "_busy_clear"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'b0;
        acc      = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_sum", {24'h0, sum}, 32'h0);
        check("reset_carry", {31'h0, carry_out}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic",      8'h03, 8'h05, 1'b0, 8'h08, 1'b0,  9, 0, 0, 0, 0);
        run_op("wrap_ff",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1,  9, 0, 0, 0, 0);
        run_op("wrap_80",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1,  9, 0, 0, 0, 0);
        run_op("start_busy", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0,  9, 0, 0, 4, 0);
        run_op("ena_pause",  8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 12, 3, 3, 0, 0);
        run_op("acc_1",      8'hEE, 8'h20, 1'b1, 8'h30, 1'b0,  9, 0, 0, 0, 0);
        run_op("acc_2",      8'hEE, 8'hE0, 1'b1, 8'h10, 1'b1,  9, 0, 0, 0, 0);
        run_op("abort",      8'h55, 8'h55, 1'b0, 8'h00, 1'b0,  9, 0, 0, 0, 4);
        run_op("acc_zero",   8'hFF, 8'h03, 1'b1, 8'h03, 1'b0,  9, 0, 0, 0, 0);
        run_op("post_rst",   8'h01, 8'h01, 1'b0, 8'h02, 1'b0,  9, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
